// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encoding and counter-width helper for univ_shift_reg
package shift_reg_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_HOLD = 2'b00;
   localparam mode_t MODE_SHR  = 2'b01;
   localparam mode_t MODE_SHL  = 2'b10;
   localparam mode_t MODE_LOAD = 2'b11;

   // Counter must reach WIDTH-1; at least one bit even for the smallest register.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/shift_frame_ctr.sv
// rtl/shift_frame_ctr.sv - tracks shifts since the last load and flags completion of a full word
module shift_frame_ctr
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic             shift,
   output logic             busy,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (en) begin
            // A load always restarts the frame, even on what would have been the final shift.
            if (load) begin
               r_busy <= 1'b1;
               r_cnt  <= '0;
            end else if (shift && r_busy) begin
               if (r_cnt == LAST_CNT) begin
                  r_busy <= 1'b0;
                  r_cnt  <= '0;
                  r_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

   assign busy       = r_busy;
   assign shift_cnt  = r_cnt;
   assign frame_done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with framed shift-out counter
// Optional rotate path enabled by defining UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pdata,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             frame_done
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_next;
   logic             w_in_r;
   logic             w_in_l;
   logic             w_load;
   logic             w_shift;

   // Rotation just swaps the serial inputs for the bit falling off the opposite end.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   assign w_in_r = rot ? r_q[0]       : sin_r;
   assign w_in_l = rot ? r_q[WIDTH-1] : sin_l;
`else
   assign w_in_r = sin_r;
   assign w_in_l = sin_l;
`endif

   assign w_load  = (mode_t'(mode) == MODE_LOAD);
   assign w_shift = (mode_t'(mode) == MODE_SHR) || (mode_t'(mode) == MODE_SHL);

   always_comb begin
      w_q_next = r_q;
      case (mode_t'(mode))
         MODE_SHR:  w_q_next = {w_in_r, r_q[WIDTH-1:1]};
         MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], w_in_l};
         MODE_LOAD: w_q_next = pdata;
         default:   w_q_next = r_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= w_q_next;
      end
   end

   shift_frame_ctr #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_frame_ctr (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (w_load),
      .shift      (w_shift),
      .busy       (busy),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done)
   );

   assign q      = r_q;
   assign sout_r = r_q[0];
   assign sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg (WIDTH=4)
module tb_univ_shift_reg;

   localparam int WIDTH = 4;
   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   logic             en;
   logic [1:0]       mode;
   logic             sin_r;
   logic             sin_l;
   logic [WIDTH-1:0] pdata;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   logic             rot;
`endif
   logic [WIDTH-1:0] q;
   logic             sout_r;
   logic             sout_l;
   logic             busy;
   logic [CNT_W-1:0] shift_cnt;
   logic             frame_done;

   int n_vec;
   int n_err;

   univ_shift_reg #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode       (mode),
      .sin_r      (sin_r),
      .sin_l      (sin_l),
      .pdata      (pdata),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      .rot        (rot),
`endif
      .q          (q),
      .sout_r     (sout_r),
      .sout_l     (sout_l),
      .busy       (busy),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [3:0] eq, input logic eb,
                               input logic [1:0] ec, input logic ef);
      check({tag, ".q"},    32'(q),          32'(eq));
      check({tag, ".busy"}, 32'(busy),       32'(eb));
      check({tag, ".cnt"},  32'(shift_cnt),  32'(ec));
      check({tag, ".fd"},   32'(frame_done), 32'(ef));
   endtask

   task automatic load(input logic [3:0] d);
      mode  = 2'b11;
      pdata = d;
      step();
   endtask

   logic [3:0] t2_sout;
   logic [3:0] t3_q [4];
   logic [3:0] t3_sl;

   initial begin
      n_vec = 0;
      n_err = 0;
      en    = 1'b1;
      sin_r = 1'b0;
      sin_l = 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      rot   = 1'b0;
`endif

      // Reset overrides a pending load
      rst   = 1'b0;
      mode  = 2'b11;
      pdata = 4'hF;
      step();
      step();
      expect_state("reset", 4'h0, 1'b0, 2'd0, 1'b0);
      rst = 1'b1;
      load(4'hF);
      expect_state("first_load", 4'hF, 1'b1, 2'd0, 1'b0);

      // Load 1011, shift right x4 with sin_r=0
      load(4'b1011);
      t2_sout = 4'b1011;
      mode  = 2'b01;
      sin_r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("shr_sout%0d", i), 32'(sout_r), 32'(t2_sout[i]));
         step();
         check($sformatf("shr_cnt%0d", i), 32'(shift_cnt), (i == 3) ? 32'd0 : 32'(i + 1));
         check($sformatf("shr_fd%0d", i), 32'(frame_done), (i == 3) ? 32'd1 : 32'd0);
      end
      expect_state("shr_end", 4'h0, 1'b0, 2'd0, 1'b1);
      mode = 2'b00;
      step();
      check("shr_fd_pulse", 32'(frame_done), 32'd0);

      // Load 0001, shift left x4 with sin_l=1
      load(4'b0001);
      t3_q[0] = 4'b0011;
      t3_q[1] = 4'b0111;
      t3_q[2] = 4'b1111;
      t3_q[3] = 4'b1111;
      t3_sl   = 4'b1100;
      mode  = 2'b10;
      sin_l = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("shl_q%0d", i), 32'(q), 32'(t3_q[i]));
         check($sformatf("shl_sout%0d", i), 32'(sout_l), 32'(t3_sl[i]));
         check($sformatf("shl_cnt%0d", i), 32'(shift_cnt), (i == 3) ? 32'd0 : 32'(i + 1));
         check($sformatf("shl_fd%0d", i), 32'(frame_done), (i == 3) ? 32'd1 : 32'd0);
      end

      // Stall mid-frame: en low then hold, then finish with mixed direction
      load(4'b0110);
      mode  = 2'b01;
      sin_r = 1'b0;
      step();
      step();
      expect_state("stall_pre", 4'b0001, 1'b1, 2'd2, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_state($sformatf("stall_en%0d", i), 4'b0001, 1'b1, 2'd2, 1'b0);
      end
      en   = 1'b1;
      mode = 2'b00;
      step();
      expect_state("stall_hold", 4'b0001, 1'b1, 2'd2, 1'b0);
      mode  = 2'b10;
      sin_l = 1'b0;
      step();
      expect_state("stall_s3", 4'b0010, 1'b1, 2'd3, 1'b0);
      step();
      expect_state("stall_s4", 4'b0100, 1'b0, 2'd0, 1'b1);
      sin_l = 1'b1;
      step();
      expect_state("idle_shift", 4'b1001, 1'b0, 2'd0, 1'b0);

      // en low on the cycle after a final shift still clears frame_done
      load(4'h0);
      mode = 2'b01;
      sin_r = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("en0_fd_set", 32'(frame_done), 32'd1);
      en = 1'b0;
      step();
      check("en0_fd_clr", 32'(frame_done), 32'd0);
      en = 1'b1;

      // Reload on the would-be final shift
      load(4'hA);
      mode  = 2'b01;
      sin_r = 1'b1;
      for (int i = 0; i < 3; i++) step();
      expect_state("reload_pre", 4'b1111, 1'b1, 2'd3, 1'b0);
      load(4'h5);
      expect_state("reload", 4'h5, 1'b1, 2'd0, 1'b0);
      mode = 2'b00;
      step();
      check("reload_nofd", 32'(frame_done), 32'd0);

      // Reset mid-frame
      mode = 2'b01;
      step();
      step();
      rst = 1'b0;
      step();
      expect_state("rst_mid", 4'h0, 1'b0, 2'd0, 1'b0);
      check("rst_sout", 32'({sout_l, sout_r}), 32'd0);
      rst = 1'b1;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
      load(4'b1000);
      rot   = 1'b1;
      mode  = 2'b01;
      sin_r = 1'b1;
      step();
      expect_state("rot0", 4'b0100, 1'b1, 2'd1, 1'b0);
      step();
      expect_state("rot1", 4'b0010, 1'b1, 2'd2, 1'b0);
      step();
      expect_state("rot2", 4'b0001, 1'b1, 2'd3, 1'b0);
      step();
      expect_state("rot3", 4'b1000, 1'b0, 2'd0, 1'b1);
      mode  = 2'b10;
      sin_l = 1'b0;
      step();
      expect_state("rotl", 4'b0001, 1'b0, 2'd0, 1'b0);
      rot = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
